aes_tcdm_responder: RTL and testbench
=====================================

AES_TCDM_RESPONDER -- requirements
Module: aes_tcdm_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, meaning the number of 32-bit words in internal storage (power of two, 16..4096).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to word 0.
REQ-003 SHALL have parameter LATENCY, default 1, meaning the number of cycles from accepted read to r_valid (legal 1..4).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, the reset: asynchronous and active-high.
REQ-006 SHALL have port clear, input, 1, a synchronous soft clear.
REQ-007 SHALL have port tcdm_req, input, 1, the request valid from the initiator.
REQ-008 SHALL have port tcdm_gnt, output, 1, the request grant.
REQ-009 SHALL have port tcdm_add, input, 32, the byte address.
REQ-010 SHALL have port tcdm_wen, input, 1, where 1 = read and 0 = write.
REQ-011 SHALL have port tcdm_be, input, 4, the write byte enables.
REQ-012 SHALL have port tcdm_data, input, 32, the write data.
REQ-013 SHALL have port tcdm_r_data, output, 32, the read data.
REQ-014 SHALL have port tcdm_r_valid, output, 1, the read data valid strobe.
REQ-015 SHALL have port stall, input, 1, which forces the grant low (backpressure injection).
REQ-016 SHALL have port err, output, 1, a sticky access-error flag.
REQ-017 SHALL have ports rd_count and wr_count, outputs, 16 bits each, counting accepted reads and accepted writes.

Function
REQ-018 SHALL drive tcdm_gnt = tcdm_req & ~stall combinationally; there is no other backpressure source.
REQ-019 SHALL treat a transaction as accepted on a rising edge where tcdm_req & tcdm_gnt = 1; the initiator's add/wen/be/data are sampled only then.
REQ-020 SHALL compute the word index as (tcdm_add - BASE_ADDR) >> 2.
REQ-021 SHALL flag an access as invalid when any of these holds: tcdm_add[1:0] != 0, tcdm_add < BASE_ADDR, or index >= MEM_WORDS.
REQ-022 SHALL, on an accepted valid write, update only the bytes of mem[index] whose tcdm_be bit is set, at the accepting edge.
REQ-023 SHALL drop an accepted invalid write (memory unchanged) and set err.
REQ-024 SHALL, on an accepted read, assert tcdm_r_valid for exactly one cycle, exactly LATENCY cycles after the accepting edge.
REQ-025 SHALL, in that same cycle, present tcdm_r_data = mem[index] as sampled at the accepting edge, or 32'hDEAD_BEEF if the read was invalid (which also sets err).
REQ-026 SHALL sustain back-to-back reads, one per cycle, using a LATENCY-deep valid/data pipeline; responses SHALL return in order with no bubbles added.
REQ-027 SHALL return the written value when a read is accepted in any cycle after an accepted write to the same word.
REQ-028 SHALL never assert tcdm_r_valid for writes.
REQ-029 SHALL hold tcdm_r_data at 0 whenever tcdm_r_valid = 0.
REQ-030 SHALL increment rd_count and wr_count by 1 per accepted read or write respectively, including invalid ones; 16'hFFFF + 1 wraps to 0.
REQ-031 SHALL keep err at 1 once set, until clear or reset.
REQ-032 SHALL, on clear = 1, flush all in-flight read responses (no r_valid for them) and zero err and both counters on that edge.
REQ-033 SHALL, when clear = 1 coincides with a request, still grant and accept that request per REQ-018; the accepted request's memory write takes effect, but its read response and counter increment are discarded.
REQ-034 SHALL leave memory contents unchanged on clear.

Reset
REQ-035 SHALL, while reset = 1, force tcdm_r_valid = 0, tcdm_r_data = 0, err = 0, rd_count = 0, wr_count = 0, and empty the read pipeline, asynchronously.
REQ-036 SHALL leave memory contents undefined after reset; benches SHALL write before reading.
REQ-037 SHALL, when reset is asserted mid-operation, produce no r_valid from any read accepted before reset.

Verification
REQ-038 SHALL be covered by a write-then-read test: write 32'h0123_4567 with be = 4'hF to BASE_ADDR+8, then read it with LATENCY = 1 -> r_valid one cycle after accept, r_data = 32'h0123_4567, wr_count = 1, rd_count = 1.
REQ-039 SHALL be covered by a byte-enable test: word holds 32'hFFFF_FFFF, write 32'h0000_0000 with be = 4'b0101 -> read returns 32'hFF00_FF00.
REQ-040 SHALL be covered by a streaming test with LATENCY = 3: four back-to-back reads of BASE_ADDR+0/4/8/12 -> r_valid high for four consecutive cycles starting 3 cycles after the first accept, data in order.
REQ-041 SHALL be covered by a stall test: req held high, stall high for 5 cycles -> gnt = 0 for those cycles, no acceptance, counters unchanged; gnt rises the cycle stall drops.
REQ-042 SHALL be covered by an error test: read BASE_ADDR + 4*MEM_WORDS, then write BASE_ADDR+2 -> r_data = 32'hDEAD_BEEF with r_valid, err = 1 and sticky, memory unchanged; clear -> err = 0.
REQ-043 SHALL be covered by a flush test with LATENCY = 4: 2 reads in flight, then clear pulse (or reset) -> no r_valid appears, rd_count = 0.

Source files
------------

// File: rtl/aes_tcdm_responder.sv
// TCDM slave memory: byte-masked writes, reads returned through a fixed-depth pipeline, sticky error flag, access counters.
// Latency: writes land at the accepting edge; read data appears exactly LATENCY cycles after acceptance.
// Backpressure: grant is req & ~stall only; once granted, the read pipeline never stalls and sustains one read per cycle.
module aes_tcdm_responder #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        tcdm_req,
  output logic        tcdm_gnt,
  input  logic [31:0] tcdm_add,
  input  logic        tcdm_wen,
  input  logic [3:0]  tcdm_be,
  input  logic [31:0] tcdm_data,
  output logic [31:0] tcdm_r_data,
  output logic        tcdm_r_valid,
  input  logic        stall,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic              accept;
  logic              rd_acc;
  logic [31:0]       offset;
  logic [31:0]       word_off;
  logic [IDX_W-1:0]  idx;
  logic              invalid;
  logic [31:0]       rd_word;

  logic [31:0]       mem_q [MEM_WORDS];

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];

  logic               err_q, err_d;
  logic [15:0]        rd_cnt_q, rd_cnt_d;
  logic [15:0]        wr_cnt_q, wr_cnt_d;

  assign tcdm_gnt = tcdm_req & ~stall;
  assign accept   = tcdm_req & tcdm_gnt;

  // Word index relative to the base; the upper bits of word_off feed the range check.
  assign offset   = tcdm_add - BASE_ADDR;
  assign word_off = offset >> 2;
  assign idx      = word_off[IDX_W-1:0];
  assign invalid  = (tcdm_add[1:0] != 2'b00) || (tcdm_add < BASE_ADDR) ||
                    (word_off >= 32'(MEM_WORDS));

  // Read data is taken from the array at the accepting edge; bad addresses read as a marker.
  assign rd_word  = invalid ? 32'hDEAD_BEEF : mem_q[idx];

  // A read accepted in a clear cycle is discarded, so it never enters the pipeline.
  assign rd_acc   = accept & tcdm_wen & ~clear;

  // Storage: byte-masked write of valid accepted writes; clear does not touch contents.
  always_ff @(posedge clk) begin
    if (accept && !tcdm_wen && !invalid) begin
      for (int b = 0; b < 4; b++) begin
        if (tcdm_be[b]) mem_q[idx][8*b +: 8] <= tcdm_data[8*b +: 8];
      end
    end
  end

  // Next state of the response pipeline: load stage 0, shift the rest, wipe everything on clear.
  always_comb begin
    vld_d[0] = rd_acc;
    dat_d[0] = rd_acc ? rd_word : 32'h0;
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_d[i] = vld_q[i-1] & ~clear;
      dat_d[i] = clear ? 32'h0 : dat_q[i-1];
    end
  end

  // Next state of the error flag and access counters; clear wins over a coincident access.
  always_comb begin
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (clear) begin
      err_d    = 1'b0;
      rd_cnt_d = 16'h0;
      wr_cnt_d = 16'h0;
    end else if (accept) begin
      if (invalid) err_d = 1'b1;
      if (tcdm_wen) rd_cnt_d = rd_cnt_q + 16'd1;
      else          wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // State registers; reset empties the pipeline so no pre-reset read ever responds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      dat_q    <= '{default: 32'h0};
      err_q    <= 1'b0;
      rd_cnt_q <= 16'h0;
      wr_cnt_q <= 16'h0;
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Stage data is zero whenever its valid bit is clear, so r_data idles at zero.
  assign tcdm_r_valid = vld_q[LATENCY-1];
  assign tcdm_r_data  = dat_q[LATENCY-1];
  assign err          = err_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_aes_tcdm_responder.sv
// Bench for aes_tcdm_responder: three instances (LATENCY 1, 3, 4) share one stimulus stream.
// A queue-based model predicts every response by due cycle; a negedge process compares all outputs.
// Directed sequences pin literal values; randomized traffic covers stalls, bad addresses, clears and resets.
module tb_aes_tcdm_responder;

  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        tcdm_req = 1'b0;
  logic        stall = 1'b0;
  logic        tcdm_wen = 1'b1;
  logic [31:0] tcdm_add = 32'h0;
  logic [31:0] tcdm_data = 32'h0;
  logic [3:0]  tcdm_be = 4'h0;

  logic        gnt     [3];
  logic [31:0] r_data  [3];
  logic        r_valid [3];
  logic        err_o   [3];
  logic [15:0] rdc     [3];
  logic [15:0] wrc     [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_tcdm_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .clear(clear), .tcdm_req(tcdm_req), .tcdm_gnt(gnt[0]),
    .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(r_data[0]), .tcdm_r_valid(r_valid[0]), .stall(stall), .err(err_o[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0]));

  aes_tcdm_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .clear(clear), .tcdm_req(tcdm_req), .tcdm_gnt(gnt[1]),
    .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(r_data[1]), .tcdm_r_valid(r_valid[1]), .stall(stall), .err(err_o[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1]));

  aes_tcdm_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .clear(clear), .tcdm_req(tcdm_req), .tcdm_gnt(gnt[2]),
    .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(r_data[2]), .tcdm_r_valid(r_valid[2]), .stall(stall), .err(err_o[2]),
    .rd_count(rdc[2]), .wr_count(wrc[2]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] mem [MW];
  rsp_t        q0[$];
  rsp_t        q1[$];
  rsp_t        q2[$];
  int          cyc = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_rd = 16'h0;
  logic [15:0] m_wr = 16'h0;
  logic        m_acc;
  logic        m_bad;
  logic [31:0] m_rdata;
  int          m_k;
  rsp_t        m_r;

  function automatic logic addr_bad(input logic [31:0] a);
    longint la;
    la = {32'h0, a};
    return (la % 4 != 0) || (la < {32'h0, BASE}) || ((la - {32'h0, BASE}) / 4 >= MW);
  endfunction

  task automatic flush_model();
    q0.delete();
    q1.delete();
    q2.delete();
    m_err = 1'b0;
    m_rd  = 16'h0;
    m_wr  = 16'h0;
  endtask

  initial forever begin
    @(posedge reset);
    flush_model();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      m_acc   = tcdm_req && !stall;
      m_bad   = addr_bad(tcdm_add);
      m_rdata = 32'hDEAD_BEEF;
      m_k     = m_bad ? 0 : int'((tcdm_add - BASE) / 4);
      if (m_acc && tcdm_wen && !m_bad) m_rdata = mem[m_k];
      if (m_acc && !tcdm_wen && !m_bad) begin
        for (int b = 0; b < 4; b++)
          if (tcdm_be[b]) mem[m_k][8*b +: 8] = tcdm_data[8*b +: 8];
      end
      if (clear) begin
        flush_model();
      end else if (m_acc) begin
        if (m_bad) m_err = 1'b1;
        if (tcdm_wen) begin
          m_rd++;
          m_r.data = m_rdata;
          m_r.due = 32'(cyc);     q0.push_back(m_r);
          m_r.due = 32'(cyc + 2); q1.push_back(m_r);
          m_r.due = 32'(cyc + 3); q2.push_back(m_r);
        end else begin
          m_wr++;
        end
      end
    end
  end

  task automatic pop_exp(input int d, output logic v, output logic [31:0] data);
    v = 1'b0;
    data = 32'h0;
    case (d)
      0: if (q0.size() > 0 && q0[0].due == 32'(cyc)) begin v = 1'b1; data = q0[0].data; void'(q0.pop_front()); end
      1: if (q1.size() > 0 && q1[0].due == 32'(cyc)) begin v = 1'b1; data = q1[0].data; void'(q1.pop_front()); end
      default: if (q2.size() > 0 && q2[0].due == 32'(cyc)) begin v = 1'b1; data = q2[0].data; void'(q2.pop_front()); end
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic        ev;
    logic [31:0] ed;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      ev = 1'b0;
      ed = 32'h0;
      if (!reset) pop_exp(d, ev, ed);
      chk($sformatf("r_valid[%0d]", d), 32'(r_valid[d]), 32'(ev));
      chk($sformatf("r_data[%0d]", d), r_data[d], ed);
      chk($sformatf("err[%0d]", d), 32'(err_o[d]), 32'(m_err));
      chk($sformatf("rd_count[%0d]", d), 32'(rdc[d]), 32'(m_rd));
      chk($sformatf("wr_count[%0d]", d), 32'(wrc[d]), 32'(m_wr));
      chk($sformatf("gnt[%0d]", d), 32'(gnt[d]), 32'(tcdm_req & ~stall));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    tcdm_req  = 1'b1;
    tcdm_wen  = wen;
    tcdm_add  = a;
    tcdm_be   = be;
    tcdm_data = d;
  endtask

  task automatic idle(input int n);
    tcdm_req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    tcdm_req = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < MW; i++) begin
      drive(1'b0, BASE + 32'(4 * i), 4'hF, {16'hC0DE, 16'(i)});
      step();
    end
    idle(1);
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 16)       return BASE + 32'(4 * $urandom_range(0, MW - 1));
    else if (r == 16) return BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(1, 3));
    else if (r == 17) return BASE - 32'(4 * $urandom_range(1, 4));
    else if (r == 18) return BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 8));
    else              return $urandom;
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      tcdm_req  = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      tcdm_wen  = $urandom_range(0, 1) == 1;
      tcdm_add  = rnd_addr();
      tcdm_be   = 4'($urandom_range(0, 15));
      tcdm_data = $urandom;
      clear     = ($urandom_range(0, 49) == 0);
      step();
    end
    stall = 1'b0;
    clear = 1'b0;
    idle(5);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    step();
    step();
    chk("reset r_valid", 32'(r_valid[0]), 32'h0);
    chk("reset rd_count", 32'(rdc[2]), 32'h0);
    reset = 1'b0;
    step();

    // Write then read, LATENCY 1.
    drive(1'b0, BASE + 32'd8, 4'hF, 32'h0123_4567);
    step();
    drive(1'b1, BASE + 32'd8, 4'h0, 32'h0);
    step();
    tcdm_req = 1'b0;
    chk("wr_rd r_valid L1", 32'(r_valid[0]), 32'h1);
    chk("wr_rd r_data L1", r_data[0], 32'h0123_4567);
    chk("wr_rd wr_count", 32'(wrc[0]), 32'h1);
    chk("wr_rd rd_count", 32'(rdc[0]), 32'h1);
    chk("wr_rd r_valid L3 early", 32'(r_valid[1]), 32'h0);
    idle(5);

    pulse_clear();
    fill();

    // Byte enables.
    drive(1'b0, BASE + 32'd80, 4'hF, 32'hFFFF_FFFF);
    step();
    drive(1'b0, BASE + 32'd80, 4'b0101, 32'h0000_0000);
    step();
    drive(1'b1, BASE + 32'd80, 4'h0, 32'h0);
    step();
    tcdm_req = 1'b0;
    chk("be r_data", r_data[0], 32'hFF00_FF00);
    idle(5);

    // Streaming reads, LATENCY 3.
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, BASE + 32'(4 * k), 4'h0, 32'h0);
      else       tcdm_req = 1'b0;
      step();
      chk($sformatf("stream valid k%0d", k), 32'(r_valid[1]), (k >= 2 && k <= 5) ? 32'h1 : 32'h0);
      chk($sformatf("stream data k%0d", k), r_data[1], (k >= 2 && k <= 5) ? 32'hC0DE_0000 + 32'(k - 2) : 32'h0);
    end
    idle(2);

    // Stall holds the grant low.
    pulse_clear();
    drive(1'b1, BASE + 32'd4, 4'h0, 32'h0);
    stall = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall gnt c%0d", k), 32'(gnt[0]), 32'h0);
      step();
      chk($sformatf("stall rd_count c%0d", k), 32'(rdc[0]), 32'h0);
    end
    stall = 1'b0;
    #1;
    chk("stall release gnt", 32'(gnt[0]), 32'h1);
    step();
    tcdm_req = 1'b0;
    chk("stall release rd_count", 32'(rdc[0]), 32'h1);
    idle(5);

    // Error handling.
    drive(1'b1, BASE + 32'(4 * MW), 4'h0, 32'h0);
    step();
    tcdm_req = 1'b0;
    chk("err r_valid", 32'(r_valid[0]), 32'h1);
    chk("err r_data", r_data[0], 32'hDEAD_BEEF);
    chk("err set", 32'(err_o[0]), 32'h1);
    drive(1'b0, BASE + 32'd2, 4'hF, 32'h1234_5678);
    step();
    idle(3);
    chk("err sticky", 32'(err_o[1]), 32'h1);
    drive(1'b1, BASE, 4'h0, 32'h0);
    step();
    tcdm_req = 1'b0;
    chk("err mem unchanged", r_data[0], 32'hC0DE_0000);
    idle(4);
    pulse_clear();
    chk("err cleared", 32'(err_o[0]), 32'h0);

    // Flush in-flight reads with clear, LATENCY 4.
    drive(1'b1, BASE + 32'd4, 4'h0, 32'h0);
    step();
    drive(1'b1, BASE + 32'd8, 4'h0, 32'h0);
    step();
    pulse_clear();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("flush r_valid c%0d", k), 32'(r_valid[2]), 32'h0);
      chk($sformatf("flush rd_count c%0d", k), 32'(rdc[2]), 32'h0);
      step();
    end

    random_phase(800);

    // Reset with reads in flight.
    drive(1'b1, BASE + 32'd12, 4'h0, 32'h0);
    step();
    drive(1'b1, BASE + 32'd16, 4'h0, 32'h0);
    step();
    tcdm_req = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset flush r_valid c%0d", k), 32'(r_valid[2]), 32'h0);
      step();
    end
    chk("reset flush rd_count", 32'(rdc[2]), 32'h0);

    fill();
    random_phase(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
